blinker_bank: RTL and testbench

BLINKER_BANK -- requirements
Module: blinker_bank

---
 rtl/blinker_bank.sv | 150 +++++++++++++++
 tb/tb_blinker_bank.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blinker_bank.sv
// Bank of independent LED-style blinker channels sharing one half-period/burst configuration.
// Latency: every output is registered, so an input change shows one rising clk edge later.
// Backpressure: none; a low per-channel switch freezes that channel's counter and outputs.
module blinker_bank #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8,
    parameter int BURST_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CHANNELS-1:0]   switch,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic                  cfg_load,
    input  logic [CNT_W-1:0]      cfg_half_period,
    input  logic [BURST_W-1:0]    cfg_burst,
    output logic [CHANNELS-1:0]   out,
    output logic [CHANNELS-1:0]   busy,
    output logic [CHANNELS-1:0]   done
);

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_SOLID = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    logic [CNT_W-1:0]   half_q, half_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [CNT_W-1:0]   half_m1;

    // A zero is coerced to one at latch time so half_m1 can never underflow.
    always_comb begin
        half_d  = half_q;
        burst_d = burst_q;
        if (cfg_load) begin
            half_d  = (cfg_half_period == '0) ? CNT_W'(1) : cfg_half_period;
            burst_d = (cfg_burst == '0) ? BURST_W'(1) : cfg_burst;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            half_q  <= CNT_W'(1);
            burst_q <= BURST_W'(1);
        end else begin
            half_q  <= half_d;
            burst_q <= burst_d;
        end
    end

    assign half_m1 = half_q - CNT_W'(1);

    for (genvar i = 0; i < CHANNELS; i++) begin : gen_ch
        logic [CNT_W-1:0]   cnt_q, cnt_d;
        logic [BURST_W-1:0] rem_q, rem_d;
        logic               out_q, out_d;
        logic               busy_q, busy_d;
        logic               done_q, done_d;
        logic [1:0]         pm_q;
        logic [1:0]         md;
        logic               mode_chg;
        logic               wrap;

        assign md       = mode[2*i +: 2];
        assign mode_chg = (md != pm_q);
        // >= rather than == so a shrinking half-period forces a toggle instead of a long wrap.
        assign wrap     = (cnt_q >= half_m1);

        always_comb begin
            cnt_d  = cnt_q;
            rem_d  = rem_q;
            out_d  = out_q;
            busy_d = busy_q;
            done_d = 1'b0;
            if (md == MODE_BURST && pm_q != MODE_BURST) begin
                rem_d  = burst_q;
                cnt_d  = '0;
                out_d  = 1'b0;
                busy_d = 1'b1;
            end else if (switch[i]) begin
                case (md)
                    MODE_OFF: begin
                        cnt_d  = '0;
                        out_d  = 1'b0;
                        busy_d = 1'b0;
                    end
                    MODE_SOLID: begin
                        cnt_d  = '0;
                        out_d  = 1'b1;
                        busy_d = 1'b0;
                    end
                    MODE_BLINK: begin
                        busy_d = 1'b1;
                        if (mode_chg) begin
                            cnt_d = '0;
                        end else if (wrap) begin
                            cnt_d = '0;
                            out_d = ~out_q;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    MODE_BURST: begin
                        // Finished bursts (rem_q == 0) hold out low until the mode re-enters.
                        if (rem_q != '0) begin
                            if (wrap) begin
                                cnt_d = '0;
                                out_d = ~out_q;
                                if (out_q) begin
                                    rem_d = rem_q - BURST_W'(1);
                                    if (rem_q == BURST_W'(1)) begin
                                        busy_d = 1'b0;
                                        done_d = 1'b1;
                                    end
                                end
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        cnt_d = cnt_q;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_q  <= '0;
                rem_q  <= '0;
                out_q  <= 1'b0;
                busy_q <= 1'b0;
                done_q <= 1'b0;
                pm_q   <= MODE_OFF;
            end else begin
                cnt_q  <= cnt_d;
                rem_q  <= rem_d;
                out_q  <= out_d;
                busy_q <= busy_d;
                done_q <= done_d;
                pm_q   <= md;
            end
        end

        assign out[i]  = out_q;
        assign busy[i] = busy_q;
        assign done[i] = done_q;
    end

endmodule

// File: tb/tb_blinker_bank.sv
// Directed scenarios for blinker_bank: blink timing, bursts, config shrink, freeze, mixed modes, async reset.
module tb_blinker_bank;

    logic       clk;
    logic       reset;
    logic [3:0] sw;
    logic [7:0] mode;
    logic       cfg_load;
    logic [7:0] cfg_hp;
    logic [3:0] cfg_b;
    logic [3:0] d_out;
    logic [3:0] d_busy;
    logic [3:0] d_done;

    int total;
    int bad;

    blinker_bank #(.CHANNELS(4), .CNT_W(8), .BURST_W(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .switch          (sw),
        .mode            (mode),
        .cfg_load        (cfg_load),
        .cfg_half_period (cfg_hp),
        .cfg_burst       (cfg_b),
        .out             (d_out),
        .busy            (d_busy),
        .done            (d_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        total++;
        if (d_out !== 4'h0) begin bad++; $display("FAIL reset_out_async: got %h want 0", d_out); end
        total++;
        if (d_busy !== 4'h0) begin bad++; $display("FAIL reset_busy_async: got %h want 0", d_busy); end
        total++;
        if (d_done !== 4'h0) begin bad++; $display("FAIL reset_done_async: got %h want 0", d_done); end
        step(2);
        total++;
        if (d_out !== 4'h0 || d_busy !== 4'h0) begin
            bad++; $display("FAIL reset_held: out=%h busy=%h want 0 0", d_out, d_busy);
        end
        reset = 1'b1;
    endtask

    task automatic test_blink();
        logic [8:0] exp_out;
        exp_out  = 9'b1_0001_1100;
        cfg_hp   = 8'd3;
        cfg_load = 1'b1;
        sw       = 4'hF;
        step(1);
        cfg_load  = 1'b0;
        mode[1:0] = 2'b10;
        step(1);
        total++;
        if (d_busy[0] !== 1'b1 || d_out[0] !== 1'b0) begin
            bad++; $display("FAIL blink_entry: busy=%b out=%b want 1 0", d_busy[0], d_out[0]);
        end
        for (int k = 1; k <= 9; k++) begin
            step(1);
            total++;
            if (d_out[0] !== exp_out[k-1]) begin
                bad++; $display("FAIL blink_out edge %0d: got %b want %b", k, d_out[0], exp_out[k-1]);
            end
        end
        mode[1:0] = 2'b00;
        step(1);
        total++;
        if (d_out[0] !== 1'b0 || d_busy[0] !== 1'b0) begin
            bad++; $display("FAIL blink_to_off: out=%b busy=%b want 0 0", d_out[0], d_busy[0]);
        end
    endtask

    task automatic test_burst();
        logic [15:0] exp_out;
        logic [15:0] exp_done;
        logic [15:0] exp_busy;
        exp_out  = 16'h0666;
        exp_done = 16'h0800;
        exp_busy = 16'h07FF;
        cfg_hp   = 8'd2;
        cfg_b    = 4'd3;
        cfg_load = 1'b1;
        step(1);
        cfg_load  = 1'b0;
        mode[3:2] = 2'b11;
        step(1);
        total++;
        if (d_busy[1] !== 1'b1 || d_out[1] !== 1'b0 || d_done[1] !== 1'b0) begin
            bad++; $display("FAIL burst_entry: busy=%b out=%b done=%b want 1 0 0", d_busy[1], d_out[1], d_done[1]);
        end
        for (int k = 1; k <= 16; k++) begin
            step(1);
            total++;
            if (d_out[1] !== exp_out[k-1]) begin
                bad++; $display("FAIL burst_out edge %0d: got %b want %b", k, d_out[1], exp_out[k-1]);
            end
            total++;
            if (d_done[1] !== exp_done[k-1]) begin
                bad++; $display("FAIL burst_done edge %0d: got %b want %b", k, d_done[1], exp_done[k-1]);
            end
            total++;
            if (d_busy[1] !== exp_busy[k-1]) begin
                bad++; $display("FAIL burst_busy edge %0d: got %b want %b", k, d_busy[1], exp_busy[k-1]);
            end
        end
        mode[3:2] = 2'b00;
        step(1);
    endtask

    task automatic test_cfg_shrink();
        logic [5:0] exp_out;
        exp_out  = 6'b100110;
        cfg_hp   = 8'd8;
        cfg_load = 1'b1;
        step(1);
        cfg_load  = 1'b0;
        mode[1:0] = 2'b10;
        step(1);
        step(6);
        total++;
        if (d_out[0] !== 1'b0) begin bad++; $display("FAIL shrink_pre: got %b want 0", d_out[0]); end
        cfg_hp   = 8'd2;
        cfg_load = 1'b1;
        for (int k = 7; k <= 12; k++) begin
            step(1);
            cfg_load = 1'b0;
            total++;
            if (d_out[0] !== exp_out[k-7]) begin
                bad++; $display("FAIL shrink_out edge %0d: got %b want %b", k, d_out[0], exp_out[k-7]);
            end
        end
        mode[1:0] = 2'b00;
        step(1);
    endtask

    task automatic test_freeze();
        logic [2:0] exp_out;
        exp_out   = 3'b100;
        mode[5:4] = 2'b10;
        step(1);
        step(3);
        total++;
        if (d_out[2] !== 1'b1) begin bad++; $display("FAIL freeze_pre: got %b want 1", d_out[2]); end
        sw[2] = 1'b0;
        for (int k = 4; k <= 8; k++) begin
            step(1);
            total++;
            if (d_out[2] !== 1'b1 || d_busy[2] !== 1'b1 || d_done[2] !== 1'b0) begin
                bad++; $display("FAIL freeze_hold edge %0d: out=%b busy=%b done=%b want 1 1 0", k, d_out[2], d_busy[2], d_done[2]);
            end
        end
        sw[2] = 1'b1;
        for (int k = 9; k <= 11; k++) begin
            step(1);
            total++;
            if (d_out[2] !== exp_out[k-9]) begin
                bad++; $display("FAIL freeze_resume edge %0d: got %b want %b", k, d_out[2], exp_out[k-9]);
            end
        end
    endtask

    task automatic test_mixed();
        logic [3:0] exp_out2;
        exp_out2  = 4'b1001;
        mode[1:0] = 2'b01;
        mode[3:2] = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            step(1);
            total++;
            if (d_out[0] !== 1'b1 || d_busy[0] !== 1'b0) begin
                bad++; $display("FAIL mixed_solid edge %0d: out=%b busy=%b want 1 0", k, d_out[0], d_busy[0]);
            end
            total++;
            if (d_out[1] !== 1'b0) begin
                bad++; $display("FAIL mixed_off edge %0d: got %b want 0", k, d_out[1]);
            end
            total++;
            if (d_out[2] !== exp_out2[k-1] || d_busy[2] !== 1'b1) begin
                bad++; $display("FAIL mixed_blink edge %0d: out=%b busy=%b want %b 1", k, d_out[2], d_busy[2], exp_out2[k-1]);
            end
        end
        mode = 8'h00;
        step(1);
    endtask

    task automatic test_async_reset();
        mode[7:6] = 2'b11;
        step(1);
        step(2);
        total++;
        if (d_out[3] !== 1'b1) begin bad++; $display("FAIL areset_pre: got %b want 1", d_out[3]); end
        #2 reset = 1'b0;
        #1;
        total++;
        if (d_out !== 4'h0 || d_busy !== 4'h0 || d_done !== 4'h0) begin
            bad++; $display("FAIL areset_immediate: out=%h busy=%h done=%h want 0 0 0", d_out, d_busy, d_done);
        end
        step(2);
        total++;
        if (d_done !== 4'h0 || d_out !== 4'h0) begin
            bad++; $display("FAIL areset_no_done: out=%h done=%h want 0 0", d_out, d_done);
        end
        reset = 1'b1;
        step(1);
        total++;
        if (d_busy[3] !== 1'b1 || d_out[3] !== 1'b0 || d_done[3] !== 1'b0) begin
            bad++; $display("FAIL areset_reentry: busy=%b out=%b done=%b want 1 0 0", d_busy[3], d_out[3], d_done[3]);
        end
        step(1);
        total++;
        if (d_out[3] !== 1'b1 || d_busy[3] !== 1'b1) begin
            bad++; $display("FAIL areset_pulse_hi: out=%b busy=%b want 1 1", d_out[3], d_busy[3]);
        end
        step(1);
        total++;
        if (d_out[3] !== 1'b0 || d_done[3] !== 1'b1 || d_busy[3] !== 1'b0) begin
            bad++; $display("FAIL areset_done: out=%b done=%b busy=%b want 0 1 0", d_out[3], d_done[3], d_busy[3]);
        end
        step(1);
        total++;
        if (d_done[3] !== 1'b0 || d_out[3] !== 1'b0) begin
            bad++; $display("FAIL areset_after: done=%b out=%b want 0 0", d_done[3], d_out[3]);
        end
        mode[7:6] = 2'b00;
        step(1);
    endtask

    task automatic test_zero_cfg();
        cfg_hp   = 8'd5;
        cfg_b    = 4'd4;
        cfg_load = 1'b1;
        step(1);
        cfg_hp = 8'd0;
        cfg_b  = 4'd0;
        step(1);
        cfg_load  = 1'b0;
        mode[1:0] = 2'b11;
        step(1);
        total++;
        if (d_busy[0] !== 1'b1 || d_out[0] !== 1'b0) begin
            bad++; $display("FAIL zero_entry: busy=%b out=%b want 1 0", d_busy[0], d_out[0]);
        end
        step(1);
        total++;
        if (d_out[0] !== 1'b1) begin bad++; $display("FAIL zero_hi: got %b want 1", d_out[0]); end
        step(1);
        total++;
        if (d_out[0] !== 1'b0 || d_done[0] !== 1'b1 || d_busy[0] !== 1'b0) begin
            bad++; $display("FAIL zero_done: out=%b done=%b busy=%b want 0 1 0", d_out[0], d_done[0], d_busy[0]);
        end
        step(1);
        total++;
        if (d_done[0] !== 1'b0) begin bad++; $display("FAIL zero_after: done=%b want 0", d_done[0]); end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        sw       = 4'h0;
        mode     = 8'h00;
        cfg_load = 1'b0;
        cfg_hp   = 8'd0;
        cfg_b    = 4'd0;
        test_reset();
        test_blink();
        test_burst();
        test_cfg_shrink();
        test_freeze();
        test_mixed();
        test_async_reset();
        test_zero_cfg();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
